// File: rtl/mul_sequencer.sv
// mul_sequencer
// Control sequencer for a multicycle multiplier sitting in the Execute stage.
// It holds Fetch/Decode/Execute while a multiply is in flight. When the result
// is ready it presents it for one or more cycles, and it holds the result while
// the Memory stage is stalled.
//
// Optional feature: define MUL_SEQUENCER_PERF_EN to build a saturating 16-bit
// counter of completed multiplies on MulPerfCnt. Without the macro the port is
// tied to zero and no counter flops exist.
module mul_sequencer #(
    parameter int unsigned MUL_LATENCY = 4,
    parameter logic [2:0]  MUL_OP      = 3'b100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ALUControlE,
    input  logic        ValidE,
    input  logic        FlushE,
    input  logic        StallM,
    output logic        MulStallH,
    output logic        MulDoneE,
    output logic [2:0]  MulBusyCnt,
    output logic [15:0] MulPerfCnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    // BUSY lasts MUL_LATENCY-1 cycles. It loads MUL_LATENCY-2 and leaves on
    // zero, so the cycle of issue plus the BUSY cycles cover the full
    // occupancy.
    localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 2);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic       stall_s;
    logic       done_s;

    // Next-state, busy-count and raw output decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (ValidE && (ALUControlE == MUL_OP) && !FlushE) begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = CNT_INIT;
                    stall_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 3'd0;
                end
            end
            BUSY: begin
                // A squash wins over the count. The stall drops at once so
                // the flush can move through the pipe.
                if (FlushE) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 3'd0;
                end else if (cnt_r == 3'd0) begin
                    state_nxt_s = DONE;
                    cnt_nxt_s   = 3'd0;
                    stall_s     = 1'b1;
                end else begin
                    state_nxt_s = BUSY;
                    cnt_nxt_s   = cnt_r - 3'd1;
                    stall_s     = 1'b1;
                end
            end
            DONE: begin
                // The result is presented here. No new multiply is
                // evaluated, so the instruction still sitting in Execute
                // is never issued again.
                done_s    = 1'b1;
                cnt_nxt_s = 3'd0;
                if (FlushE) begin
                    state_nxt_s = IDLE;
                end else if (!StallM) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                // The unused code recovers to IDLE and drives idle outputs
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // State and busy-count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // The hazard unit needs the stall in the issue cycle, so the stall and
    // done outputs are combinational. Both are masked while reset is held.
    always_comb begin
        if (rst) begin
            MulStallH = 1'b0;
            MulDoneE  = 1'b0;
        end else begin
            MulStallH = stall_s;
            MulDoneE  = done_s;
        end
    end

    // The busy count is cleared whenever the state leaves BUSY, so it reads
    // zero outside BUSY.
    assign MulBusyCnt = cnt_r;

`ifdef MUL_SEQUENCER_PERF_EN
    logic [15:0] perf_r;
    logic        complete_s;

    // Add one and hold at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // A completion is a DONE cycle that hands its result downstream
    assign complete_s = (state_r == DONE) && !FlushE && !StallM;

    // Saturating completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_r <= 16'd0;
        end else if (complete_s) begin
            perf_r <= sat_inc16(perf_r);
        end else begin
            perf_r <= perf_r;
        end
    end

    assign MulPerfCnt = perf_r;
`else
    assign MulPerfCnt = 16'd0;
`endif

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter MUL_LATENCY, default 4: total Execute-stage occupancy in cycles of one multiply; legal range 2..8.
REQ-002 Parameter MUL_OP, default 3'b100: ALUControlE encoding that selects multiply.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled only on rising clk.
REQ-005 ALUControlE  input  3  ALU opcode of the instruction currently in Execute.
REQ-006 ValidE  input  1  Execute holds a real instruction, not a bubble.
REQ-007 FlushE  input  1  Execute instruction is being squashed this cycle.
REQ-008 StallM  input  1  Memory stage stalled; the E->M register is frozen.
REQ-009 MulStallH  output  1  to hazard unit; freezes Fetch, Decode and Execute.
REQ-010 MulDoneE  output  1  multiply result valid at the ALU output this cycle.
REQ-011 MulBusyCnt  output  3  remaining BUSY cycles; zero outside BUSY.
REQ-012 MulPerfCnt  output  16  count of completed multiplies (see Configuration).

Function
REQ-013 States SHALL be IDLE, BUSY and DONE, with 2-bit encoding 00, 01 and 10.
REQ-014 start SHALL be defined as state==IDLE & ValidE & (ALUControlE==MUL_OP) & !FlushE.
REQ-015 IDLE SHALL go to BUSY with MulBusyCnt<=MUL_LATENCY-2 on start, and SHALL otherwise stay in IDLE.
REQ-016 BUSY with FlushE=1 SHALL go to IDLE; flush takes priority over the count.
REQ-017 BUSY with FlushE=0 and MulBusyCnt==0 SHALL go to DONE.
REQ-018 BUSY with FlushE=0 and MulBusyCnt!=0 SHALL decrement MulBusyCnt and stay in BUSY.
REQ-019 BUSY SHALL count regardless of StallM; the multiplier runs independently of downstream stalls.
REQ-020 MulStallH SHALL be combinational: 1 when start, or when state==BUSY & !FlushE; 0 otherwise.
REQ-021 Latency: start in cycle T SHALL give MulStallH=1 in cycles T..T+MUL_LATENCY-1 and state DONE in cycle T+MUL_LATENCY.
REQ-022 DONE SHALL drive MulDoneE=1 and MulStallH=0.
REQ-023 DONE with StallM=0 and FlushE=0 SHALL go to IDLE and count one completion.
REQ-024 DONE with StallM=1 and FlushE=0 SHALL hold DONE, keeping MulDoneE=1 every held cycle.
REQ-025 DONE with FlushE=1 SHALL go to IDLE with no completion counted.
REQ-026 DONE SHALL NOT evaluate start, so the same multiply is never re-issued.
REQ-027 A multiply entering Execute one cycle after DONE->IDLE SHALL start immediately, with no bubble inserted by this block.
REQ-028 MulDoneE SHALL be 0 outside DONE.
REQ-029 The unused state encoding 11 SHALL go to IDLE on the next edge, with outputs as in IDLE.

Reset
REQ-030 rst=1 at a clock edge SHALL force state IDLE, MulBusyCnt=0 and MulPerfCnt=0, overriding all other inputs.
REQ-031 While rst=1, MulStallH and MulDoneE SHALL be 0.
REQ-032 Reset asserted mid-BUSY or mid-DONE SHALL abandon the multiply with no MulDoneE pulse.

Configuration
REQ-033 With macro MUL_SEQUENCER_PERF_EN defined, MulPerfCnt SHALL increment on each DONE->IDLE completion.
REQ-034 With MUL_SEQUENCER_PERF_EN defined, MulPerfCnt SHALL saturate at 16'hFFFF.
REQ-035 With MUL_SEQUENCER_PERF_EN undefined, MulPerfCnt SHALL be constant 0, the port SHALL remain present, and no counter flops SHALL be inferred.

Verification (MUL_LATENCY=4, MUL_SEQUENCER_PERF_EN defined)
REQ-036 Single mul: ValidE=1 and ALUControlE=100 at cycle 0 -> MulStallH=1 in cycles 0-3, MulDoneE=1 in cycle 4 only, MulPerfCnt=1 in cycle 5.
REQ-037 Downstream stall: single mul with StallM=1 in cycles 4-6 -> MulDoneE=1 in cycles 4-7, MulStallH=0 in cycles 4-7, MulPerfCnt=1 in cycle 8.
REQ-038 Flush: FlushE=1 in cycle 2 of a mul -> MulStallH=0 in cycle 2, IDLE in cycle 3, no MulDoneE, MulPerfCnt unchanged.
REQ-039 Back-to-back: two muls -> MulDoneE in cycles 4 and 9, MulStallH=1 in cycles 5-8, MulPerfCnt=2.
REQ-040 Reset mid-BUSY: rst=1 in cycle 2 -> IDLE and MulBusyCnt=0 in cycle 3, no MulDoneE, MulPerfCnt=0.
REQ-041 Non-mul or bubble: ALUControlE=000, or ValidE=0 with ALUControlE=100 -> MulStallH=0 and state stays IDLE.
